fft_out_reorder: RTL and testbench



---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_pp_bank.sv | 28 ++
 rtl/fft_out_reorder.sv | 113 +++++++++++
 tb/tb_fft_out_reorder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, write-FSM state encoding and bit-reverse helper for the FFT output reorder buffer.
package fft_pkg;
   localparam int DATA_W      = 34;
   localparam int HALF_W      = 17;
   localparam int POINTS      = 16;
   localparam int LOG2_POINTS = $clog2(POINTS);
   typedef logic [1:0] wr_state_t;
   localparam wr_state_t WR_IDLE = 2'd0;
   localparam wr_state_t WR_FILL = 2'd1;
   localparam wr_state_t WR_DROP = 2'd2;
   function automatic logic [LOG2_POINTS-1:0] bitrev(input logic [LOG2_POINTS-1:0] a);
      for (int i = 0; i < LOG2_POINTS; i++) bitrev[i] = a[LOG2_POINTS-1-i];
   endfunction
endpackage

// File: rtl/fft_pp_bank.sv
// fft_pp_bank: one ping-pong bank with storage, write port, read mux and full flag.
module fft_pp_bank
   import fft_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_we,
   input  logic [LOG2_POINTS-1:0] i_waddr,
   input  logic [DATA_W-1:0]      i_wdata,
   input  logic                   i_set_full,
   input  logic                   i_clr_full,
   input  logic [LOG2_POINTS-1:0] i_raddr,
   output logic [DATA_W-1:0]      o_rdata,
   output logic                   o_full
);
   logic [DATA_W-1:0] r_mem [POINTS];
   logic              r_full;
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_full <= 1'b0;
      else if (i_set_full) r_full <= 1'b1;
      else if (i_clr_full) r_full <= 1'b0;
   end
   assign o_rdata = r_mem[i_raddr];
   assign o_full  = r_full;
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: collects FFT output frames into ping-pong banks and streams them out over valid/ready.
// Define FFT_BITREV_EN for bit-reversed write addressing (natural-order output); otherwise a plain frame buffer.
module fft_out_reorder
   import fft_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic                   in_sof,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [LOG2_POINTS-1:0] out_index,
   output logic                   out_last,
   output logic                   frame_err,
   output logic                   ovf
);
   localparam logic [LOG2_POINTS-1:0] LAST = LOG2_POINTS'(POINTS - 1);
   wr_state_t              r_state, w_state_n;
   logic [LOG2_POINTS-1:0] r_wcnt, w_wcnt_n, r_rcnt, w_wptr, w_waddr;
   logic                   r_wbank, w_wbank_n, r_rbank, r_ferr, r_ovf;
   logic                   w_wr_en, w_set_full, w_ferr, w_ovf_set, w_fire, w_rd_last;
   logic [1:0]             w_full, w_we, w_set, w_clr;
   logic [DATA_W-1:0]      w_rdata [2];

   // A sof always restarts the frame, so its sample goes to slot 0 regardless of wcnt.
   assign w_wptr = in_sof ? '0 : r_wcnt;
`ifdef FFT_BITREV_EN
   assign w_waddr = bitrev(w_wptr);
`else
   assign w_waddr = w_wptr;
`endif

   always_comb begin
      w_state_n  = r_state;
      w_wcnt_n   = r_wcnt;
      w_wbank_n  = r_wbank;
      w_wr_en    = 1'b0;
      w_set_full = 1'b0;
      w_ferr     = 1'b0;
      w_ovf_set  = 1'b0;
      if (in_valid && in_sof) begin
         w_ferr    = r_state == WR_FILL;
         w_wcnt_n  = LOG2_POINTS'(1);
         w_wr_en   = !w_full[r_wbank];
         w_ovf_set = w_full[r_wbank];
         w_state_n = w_full[r_wbank] ? WR_DROP : WR_FILL;
      end else if (in_valid) begin
         w_ferr  = r_state == WR_IDLE;
         w_wr_en = r_state == WR_FILL;
         if (r_state != WR_IDLE) begin
            w_wcnt_n = r_wcnt + LOG2_POINTS'(1);
            if (r_wcnt == LAST) begin
               w_wcnt_n   = '0;
               w_state_n  = WR_IDLE;
               w_set_full = r_state == WR_FILL;
               w_wbank_n  = r_wbank ^ (r_state == WR_FILL);
            end
         end
      end
   end

   assign w_fire    = out_valid && out_ready;
   assign w_rd_last = r_rcnt == LAST;
   assign w_we      = w_wr_en ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
   assign w_set     = w_set_full ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
   assign w_clr     = (w_fire && w_rd_last) ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_pp_bank u_bank (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_we       (w_we[b]),
         .i_waddr    (w_waddr),
         .i_wdata    (in_data),
         .i_set_full (w_set[b]),
         .i_clr_full (w_clr[b]),
         .i_raddr    (r_rcnt),
         .o_rdata    (w_rdata[b]),
         .o_full     (w_full[b])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WR_IDLE;
         r_wcnt  <= '0;
         r_wbank <= 1'b0;
         r_rbank <= 1'b0;
         r_rcnt  <= '0;
         r_ferr  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_wcnt  <= w_wcnt_n;
         r_wbank <= w_wbank_n;
         r_ferr  <= w_ferr;
         r_ovf   <= r_ovf | w_ovf_set;
         if (w_fire) begin
            r_rcnt  <= w_rd_last ? '0 : r_rcnt + LOG2_POINTS'(1);
            r_rbank <= r_rbank ^ w_rd_last;
         end
      end
   end

   assign out_valid = w_full[r_rbank];
   assign out_data  = out_valid ? w_rdata[r_rbank] : '0;
   assign out_index = r_rcnt;
   assign out_last  = out_valid && w_rd_last;
   assign frame_err = r_ferr;
   assign ovf       = r_ovf;
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: vector table, corner-case sequences and random traffic against a frame-queue model.
module tb_fft_out_reorder;
   import fft_pkg::*;
   logic                   clk = 1'b0, rst_n = 1'b0;
   logic                   in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b0;
   logic [DATA_W-1:0]      in_data = '0;
   logic                   out_valid, out_last, frame_err, ovf;
   logic [DATA_W-1:0]      out_data;
   logic [LOG2_POINTS-1:0] out_index;

   fft_out_reorder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last),
      .frame_err (frame_err),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int vecs = 0, errs = 0, ferr_seen = 0, outs = 0, cnt = 0, pos = 0;
   logic [DATA_W-1:0] fq[$];
   logic [DATA_W-1:0] cur [POINTS];
   int  nbuf = 0, ridx = 0, mode = 0, n = 0;
   bit  m_ovf = 0, m_ferr = 0;

   typedef struct {
      bit v, s, rdy;
      logic [DATA_W-1:0] d;
      bit ev, el;
      logic [DATA_W-1:0] ed;
   } vec_t;
   vec_t tbl [32];

   // Arrival position of the sample that appears at output position k.
   function automatic int order(input int k);
`ifdef FFT_BITREV_EN
      int r = 0, x = k;
      for (int i = 0; i < LOG2_POINTS; i++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
`else
      return k;
`endif
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_model();
      bit ev = nbuf > 0;
      chk("valid", 64'(out_valid), 64'(ev));
      chk("data", 64'(out_data), ev ? 64'(fq[0]) : 64'd0);
      chk("index", 64'(out_index), 64'(ridx));
      chk("last", 64'(out_last), 64'(ev && ridx == POINTS - 1));
      chk("frame_err", 64'(frame_err), 64'(m_ferr));
      chk("ovf", 64'(ovf), 64'(m_ovf));
   endtask

   task automatic step(input bit v, input bit s, input logic [DATA_W-1:0] d, input bit rdy);
      int nb0 = nbuf;
      in_valid = v; in_sof = s; in_data = d; out_ready = rdy;
      if (out_valid && rdy) outs++;
      m_ferr = 0;
      if (v && s) begin
         m_ferr = mode == 1;
         n = 1;
         if (nb0 < 2) begin cur[0] = d; mode = 1; end
         else begin m_ovf = 1; mode = 2; end
      end else if (v) begin
         if (mode == 0) m_ferr = 1;
         else begin
            if (mode == 1) cur[n] = d;
            n++;
            if (n == POINTS) begin
               if (mode == 1) begin
                  for (int k = 0; k < POINTS; k++) fq.push_back(cur[order(k)]);
                  nbuf++;
               end
               mode = 0;
            end
         end
      end
      if (nb0 > 0 && rdy) begin
         void'(fq.pop_front());
         if (ridx == POINTS - 1) begin ridx = 0; nbuf--; end
         else ridx++;
      end
      @(posedge clk);
      @(negedge clk);
      if (frame_err) ferr_seen++;
      check_model();
   endtask

   task automatic send_frame(input int base, input bit rdy);
      for (int i = 0; i < POINTS; i++) step(1, i == 0, DATA_W'(base + i), rdy);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, '0, 1);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      in_valid = 0; in_sof = 0;
      fq.delete(); nbuf = 0; ridx = 0; mode = 0; n = 0; m_ovf = 0; m_ferr = 0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_index", 64'(out_index), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      chk("rst_ferr", 64'(frame_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < POINTS; i++) begin
         tbl[i].v = 1; tbl[i].s = i == 0; tbl[i].rdy = 1; tbl[i].d = DATA_W'(i);
         tbl[i].ev = i == POINTS - 1; tbl[i].el = 0;
         tbl[i].ed = (i == POINTS - 1) ? DATA_W'(order(0)) : '0;
      end
      for (int k = 0; k < POINTS; k++) begin
         tbl[POINTS+k].v = 0; tbl[POINTS+k].s = 0; tbl[POINTS+k].rdy = 1; tbl[POINTS+k].d = '0;
         tbl[POINTS+k].ev = k < POINTS - 1; tbl[POINTS+k].el = k == POINTS - 2;
         tbl[POINTS+k].ed = (k < POINTS - 1) ? DATA_W'(order(k + 1)) : '0;
      end
      @(negedge clk);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_data", 64'(out_data), 64'd0);
      chk("reset_ovf", 64'(ovf), 64'd0);
      chk("reset_ferr", 64'(frame_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 2 * POINTS; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].rdy);
         chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
         chk("tbl_data", 64'(out_data), 64'(tbl[i].ed));
         chk("tbl_last", 64'(out_last), 64'(tbl[i].el));
      end

      ferr_seen = 0;
      for (int f = 0; f < 3; f++) send_frame(256 + f * POINTS, 0);
      chk("bb_ovf", 64'(ovf), 64'd1);
      chk("bb_ferr", 64'(ferr_seen), 64'd0);
      cnt = 0;
      for (int i = 0; i < 2 * POINTS; i++) begin
         if (out_valid) cnt++;
         step(0, 0, '0, 1);
      end
      chk("bb_nobubble", 64'(cnt), 64'(2 * POINTS));
      chk("bb_drained", 64'(out_valid), 64'd0);

      do_reset();
      ferr_seen = 0; outs = 0;
      for (int i = 0; i < 5; i++) step(1, i == 0, DATA_W'(512 + i), 1);
      send_frame(600, 1);
      idle(POINTS + 4);
      chk("early_sof_ferr", 64'(ferr_seen), 64'd1);
      chk("early_sof_outs", 64'(outs), 64'(POINTS));

      ferr_seen = 0; outs = 0;
      for (int i = 0; i < 3; i++) step(1, 0, DATA_W'(700 + i), 1);
      idle(3);
      chk("idle_ferr", 64'(ferr_seen), 64'd3);
      chk("idle_outs", 64'(outs), 64'd0);

      send_frame(800, 0);
      idle(5);
      do_reset();
      outs = 0;
      send_frame(900, 1);
      idle(POINTS + 2);
      chk("post_rst_outs", 64'(outs), 64'(POINTS));

      pos = 0;
      for (int i = 0; i < 3000; i++) begin
         bit v = ($urandom % 5) != 0;
         bit s = v && (pos == 0 || ($urandom % 50) == 0);
         if (v) pos = s ? 1 : (pos + 1) % POINTS;
         step(v, s, DATA_W'({$urandom, $urandom}), ($urandom % 4) != 0);
      end
      idle(3 * POINTS);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
